// File: rtl/RS5_pkg.sv
// rtl/RS5_pkg.sv - shared PLIC register offsets and interrupt id type
package RS5_pkg;

  localparam int PLIC_ID_W = 5;
  typedef logic [PLIC_ID_W-1:0] plic_id_t;

  localparam logic [23:0] PLIC_PRIO_BASE = 24'h000000;
  localparam logic [23:0] PLIC_PENDING   = 24'h001000;
  localparam logic [23:0] PLIC_TRIGGER   = 24'h001100;
  localparam logic [23:0] PLIC_ENABLE    = 24'h002000;
  localparam logic [23:0] PLIC_THRESHOLD = 24'h200000;
  localparam logic [23:0] PLIC_CLAIM     = 24'h200004;

endpackage

// File: rtl/plic_gateway.sv
// rtl/plic_gateway.sv - per-source gateway tracking pending/in-flight/deferred state
module plic_gateway (
  input  logic clk,
  input  logic reset,
  input  logic irq_i,
  input  logic mode,
  input  logic mode_chg,
  input  logic claim,
  input  logic complete,
  output logic pending_o,
  output logic inflight_o
);

  logic pending_q, pending_d;
  logic inflight_q, inflight_d;
  logic deferred_q, deferred_d;
  logic irq_q;
  logic rise;
  logic edge_busy;

  assign rise = irq_i & ~irq_q;
  // An edge landing on the completion edge can go straight to pending.
  assign edge_busy = (inflight_q & ~complete) | claim;

  always_comb begin
    pending_d  = pending_q & ~claim;
    inflight_d = (inflight_q & ~complete) | claim;
    deferred_d = deferred_q & ~mode_chg;
    if (mode) begin
      if (rise) begin
        if (edge_busy) deferred_d = 1'b1;
        else           pending_d  = 1'b1;
      end
    end else if (irq_i && !inflight_q && !claim) begin
      pending_d = 1'b1;
    end
    if (complete && deferred_q) begin
      deferred_d = 1'b0;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q  <= 1'b0;
      inflight_q <= 1'b0;
      deferred_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      deferred_q <= deferred_d;
      irq_q      <= irq_i;
    end
  end

  assign pending_o  = pending_q;
  assign inflight_o = inflight_q;

endmodule

// File: rtl/plic_prio.sv
// rtl/plic_prio.sv - prioritised PLIC: register file, claim/complete and registered max-scan arbiter
module plic_prio
  import RS5_pkg::*;
#(
  parameter int SOURCES = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic [3:0]         we_i,
  input  logic [23:0]        addr_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  input  logic [SOURCES:1]   irq_i,
  output logic               irq_o,
  output logic [SOURCES:1]   iack_o
);

  localparam plic_id_t SRC_ID = plic_id_t'(SOURCES);

  logic [PRIO_W-1:0] prio_q [1:SOURCES];
  logic [PRIO_W-1:0] prio_d [1:SOURCES];
  logic [SOURCES:1]  enable_q, enable_d;
  logic [SOURCES:1]  trigger_q, trigger_d;
  logic [PRIO_W-1:0] threshold_q, threshold_d;
  plic_id_t          best_id_q, best_id_d;
  logic              irq_q, irq_d;
  logic [31:0]       data_q, data_d;
  logic [SOURCES:1]  iack_q, iack_d;

  logic [SOURCES:1]  pending, inflight;
  logic [SOURCES:1]  claim_vec, complete_vec, mode_chg;
  logic              rd_en, wr_en, do_claim;
  logic              sel_prio, sel_pending, sel_trigger, sel_enable, sel_threshold, sel_claim;
  plic_id_t          prio_id;
  plic_id_t          win_id;
  logic [PRIO_W-1:0] win_prio;
  logic [31:0]       rd_word;
  logic              unused_data;

  assign unused_data = ^data_i;

  assign rd_en = en_i && (we_i == 4'b0000);
  assign wr_en = en_i && (we_i != 4'b0000);

  assign prio_id       = addr_i[6:2];
  assign sel_prio      = (addr_i[23:7] == PLIC_PRIO_BASE[23:7]) && (addr_i[1:0] == 2'b00)
                         && (prio_id != '0) && (prio_id <= SRC_ID);
  assign sel_pending   = (addr_i == PLIC_PENDING);
  assign sel_trigger   = (addr_i == PLIC_TRIGGER);
  assign sel_enable    = (addr_i == PLIC_ENABLE);
  assign sel_threshold = (addr_i == PLIC_THRESHOLD);
  assign sel_claim     = (addr_i == PLIC_CLAIM);

  // A claim only takes effect while the registered request is up.
  assign do_claim = rd_en && sel_claim && irq_q;

  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    mode_chg     = '0;
    for (int i = 1; i <= SOURCES; i++) begin
      claim_vec[i]    = do_claim && (best_id_q == plic_id_t'(i));
      complete_vec[i] = wr_en && sel_claim && (data_i[4:0] == plic_id_t'(i)) && inflight[i];
      mode_chg[i]     = wr_en && sel_trigger && (trigger_q[i] != data_i[i]);
    end
  end

  for (genvar g = 1; g <= SOURCES; g++) begin : g_gw
    plic_gateway u_gw (
      .clk        (clk),
      .reset      (reset),
      .irq_i      (irq_i[g]),
      .mode       (trigger_q[g]),
      .mode_chg   (mode_chg[g]),
      .claim      (claim_vec[g]),
      .complete   (complete_vec[g]),
      .pending_o  (pending[g]),
      .inflight_o (inflight[g])
    );
  end

  // Strict '>' in ascending id order gives ties to the lowest id and never picks priority 0.
  always_comb begin
    win_id   = '0;
    win_prio = '0;
    for (int i = 1; i <= SOURCES; i++) begin
      if (pending[i] && enable_q[i] && (prio_q[i] > win_prio)) begin
        win_id   = plic_id_t'(i);
        win_prio = prio_q[i];
      end
    end
  end

  always_comb begin
    best_id_d = do_claim ? '0 : win_id;
    irq_d     = !do_claim && (win_prio > threshold_q);
  end

  always_comb begin
    rd_word = '0;
    if (sel_prio) begin
      for (int i = 1; i <= SOURCES; i++) begin
        if (prio_id == plic_id_t'(i)) rd_word[PRIO_W-1:0] = prio_q[i];
      end
    end else if (sel_pending) begin
      rd_word[SOURCES:1] = pending;
    end else if (sel_trigger) begin
      rd_word[SOURCES:1] = trigger_q;
    end else if (sel_enable) begin
      rd_word[SOURCES:1] = enable_q;
    end else if (sel_threshold) begin
      rd_word[PRIO_W-1:0] = threshold_q;
    end else if (sel_claim && irq_q) begin
      rd_word[4:0] = best_id_q;
    end
  end

  always_comb begin
    for (int i = 1; i <= SOURCES; i++) begin
      prio_d[i] = prio_q[i];
      if (wr_en && sel_prio && (prio_id == plic_id_t'(i))) prio_d[i] = data_i[PRIO_W-1:0];
    end
    enable_d    = (wr_en && sel_enable)    ? data_i[SOURCES:1]  : enable_q;
    trigger_d   = (wr_en && sel_trigger)   ? data_i[SOURCES:1]  : trigger_q;
    threshold_d = (wr_en && sel_threshold) ? data_i[PRIO_W-1:0] : threshold_q;
    data_d      = rd_en ? rd_word : data_q;
    iack_d      = complete_vec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i <= SOURCES; i++) prio_q[i] <= '0;
      enable_q    <= '0;
      trigger_q   <= '0;
      threshold_q <= '0;
      best_id_q   <= '0;
      irq_q       <= 1'b0;
      data_q      <= '0;
      iack_q      <= '0;
    end else begin
      for (int i = 1; i <= SOURCES; i++) prio_q[i] <= prio_d[i];
      enable_q    <= enable_d;
      trigger_q   <= trigger_d;
      threshold_q <= threshold_d;
      best_id_q   <= best_id_d;
      irq_q       <= irq_d;
      data_q      <= data_d;
      iack_q      <= iack_d;
    end
  end

  assign data_o = data_q;
  assign irq_o  = irq_q;
  assign iack_o = iack_q;

endmodule

// File: doc/plic_prio.md
# plic_prio

Prioritised platform-level interrupt controller for the RS5 core. It generalises the fixed-order controller to a parametrised number of sources, with per-source priority, a global threshold, and per-source edge or level triggering. Software uses the standard claim/complete protocol: interrupts are claimed and completed through one memory-mapped register. It sits on the peripheral bus and drives the core's external interrupt line.

## Interface
- `SOURCES`, default 8: number of interrupt sources, IDs 1..SOURCES; legal range 1..31; ID 0 means "no interrupt".
- `PRIO_W`, default 3: priority width in bits; priority 0 means never taken.
- `clk`  in  1: clock. One clock domain; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `en_i`  in  1: bus access strobe, one cycle per access.
- `we_i`  in  4: write enables; any nonzero value performs a full-word write.
- `addr_i`  in  24: register offset.
- `data_i`  in  32: write data.
- `data_o`  out  32: read data.
- `irq_i`  in  [SOURCES:1]: raw source lines.
- `irq_o`  out  1: external interrupt request to the core.
- `iack_o`  out  [SOURCES:1]: one-cycle completion pulse per source.

## Operation
- Register map, word offsets. Any unmapped read returns 0; any unmapped write is ignored.
  - Priority: 0x000000 + 4·id, bits [PRIO_W-1:0].
  - Pending: 0x001000, read-only, bits [SOURCES:1].
  - Trigger: 0x001100, bit i = 1 means edge, 0 means level.
  - Enable: 0x002000.
  - Threshold: 0x200000.
  - Claim/complete: 0x200004.
- Per-source gateway state: `pending`, `inflight`, `deferred`, and `irq_q` (the registered `irq_i`).
- Level mode: `pending` is set while `irq_i` is high and `inflight` is clear.
- Edge mode: a rising edge (`irq_i & ~irq_q`) sets `pending` if `inflight` is clear; otherwise it sets `deferred`. Multiple deferred edges collapse into one.
- Changing a source's trigger mode clears its `deferred` bit.
- Arbiter selects the enabled, pending source with the highest priority. Ties go to the lowest ID.
  - The winner is registered as `best_id`/`best_prio`.
  - `irq_o` = registered (`best_prio` > threshold).
- Claim (read of 0x200004):
  - If `irq_o` is high: `data_o` = `best_id`; that source's `pending` clears and its `inflight` sets. On the same edge, `best_id`, `best_prio` and `irq_o` are forced to 0.
  - Otherwise: `data_o` = 0 and no state changes.
- Complete (write of 0x200004 with id = `data_i[4:0]`):
  - Takes effect only if 1 ≤ id ≤ SOURCES and `inflight[id]` is set. Otherwise the write is ignored and no `iack_o` pulse occurs.
  - On effect: `inflight[id]` clears and `iack_o[id]` pulses for one cycle.
  - If `deferred[id]` is set, it clears and `pending[id]` sets on the same edge.
- Simultaneous events:
  - A rising edge arriving on the claim edge for the same source goes to `deferred`.
  - Priority, enable or threshold writes take effect on arbitration at the next edge.
  - Disabling an in-flight source does not block its completion.
- Reset values: every register and state bit is 0. That includes `data_o`, `irq_o`, `iack_o`, `best_id`, priorities, enable, threshold and trigger (trigger 0 = level).

## Timing
- `irq_i` sampled at edge k:
  - `pending` and `irq_q` update at edge k.
  - `best_id` and `irq_o` update at edge k+1. Interrupt latency is therefore 2 cycles.
- Read data: `data_o` is registered and valid the cycle after the `en_i` read cycle. It holds until the next read; writes do not change it.
- Back-to-back claims on consecutive cycles: the second returns 0. After a claim, arbitration is valid again 1 cycle later.
- `iack_o` rises on the edge after the complete-write cycle and stays high for exactly one cycle.
- Level source still high at completion: `pending` sets again at the next edge, and `irq_o` reasserts 2 cycles after the completion edge.
- Reset asserted mid-operation clears all state immediately (asynchronously). `irq_o` is low while reset is high.

## Structure
- `RS5_pkg` holds:
  - Address constants `PLIC_PRIO_BASE`, `PLIC_PENDING`, `PLIC_TRIGGER`, `PLIC_ENABLE`, `PLIC_THRESHOLD`, `PLIC_CLAIM`.
  - The `plic_id_t` width rule: 5 bits, sized for the 31-source maximum.
- One sub-module, `plic_gateway`, instantiated SOURCES times. It holds `pending`, `inflight`, `deferred` and `irq_q`, and has inputs `mode`, `claim` and `complete`.
- Arbiter and register file stay in `plic_prio`. The arbiter is a linear max-scan over sources, and the arbitration stage is registered.

## Test plan
- Level source 3, priority 2, threshold 1, enabled:
  - Raise `irq_i[3]` → `irq_o` high 2 cycles later.
  - Claim → 3.
  - Complete with 3 while the line is still high → `iack_o[3]` pulses once, and `irq_o` reasserts 2 cycles later.
- Sources 2 and 5 pending at priorities 1 and 4:
  - First claim → 5.
  - Claim on the very next cycle → 0.
  - Claim two cycles later → 2.
- Equal priorities on sources 4 and 6 → claim returns 4.
- Threshold 4, source priority 4 → `irq_o` stays low and claim returns 0. Lower threshold to 3 → `irq_o` high 1 cycle later.
- Edge source 1:
  - Pulse, claim, then pulse twice while in flight → complete sets `pending` once. The next claim returns 1, and a claim after that returns 0.
- Complete with id 0, id 9 (SOURCES=8), and a non-in-flight id → no `iack_o` pulse and no state change.
- Assert reset mid-claim → `data_o`, `irq_o` and `iack_o` are 0 immediately.
